prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time writer for the instruction memory that the pipelined datapath fetches from.
- Accepts a byte stream over a valid/ready handshake and assembles bytes into 16-bit instructions.
- Writes each instruction into instruction memory at consecutive addresses starting at 0.
- Holds the CPU in reset until the full image has arrived and its checksum matches.

Parameters:
- ADDR_W, 8: instruction memory address width. Maximum image is 2**ADDR_W words.
- TIMEOUT, 65535: maximum idle cycles allowed between bytes once a load has started. 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic updates on the rising edge.
- rst  input  1  synchronous reset, active-low.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader can accept a byte. A byte is accepted when in_valid && in_ready at a clock edge.
- load_req  input  1  one-cycle pulse that aborts or restarts a load.
- im_we  output  1  instruction memory write strobe.
- im_addr  output  ADDR_W  instruction memory write address.
- im_wdata  output  16  instruction word to write.
- cpu_hold  output  1  1 = CPU held in reset.
- load_done  output  1  image loaded and checksum correct.
- load_err  output  1  checksum mismatch or timeout.
- word_count  output  ADDR_W+1  number of instructions written in the current load.

Behaviour:
- States: LEN, HI, LO, CHK, DONE, ERR.
- Reset (rst==0 at an edge):
  - state goes to LEN.
  - cpu_hold=1, im_we=0, im_addr=0, im_wdata=0, load_done=0, load_err=0, word_count=0.
  - Internal length, checksum accumulator and timeout counter are cleared.
  - Reset mid-load discards all progress. Memory already written is not scrubbed.
- in_ready is combinational: 1 in LEN, HI, LO and CHK; 0 in DONE and ERR.
- LEN:
  - Accepted byte L sets the target count N = L, with L==0 meaning N = 2**ADDR_W.
  - Checksum is initialised to L; next state is HI.
  - The timeout counter does not run in LEN.
- HI: accepted byte is latched as the high byte, checksum ^= byte, next state is LO.
- LO: on an accepted byte, checksum ^= byte and, registered so visible the cycle after acceptance:
  - im_we=1 for exactly one cycle.
  - im_wdata = {hi, lo}.
  - im_addr = word_count before increment, truncated to ADDR_W bits.
  - word_count increments.
  - Next state is CHK if the new word_count == N, otherwise HI.
- CHK: accepted byte is compared with the checksum.
  - Equal: go to DONE. load_done=1 and cpu_hold=0 from the following cycle.
  - Not equal: go to ERR. load_err=1 and cpu_hold stays 1.
- DONE and ERR hold their state until load_req or reset.
- load_req:
  - Has priority over a simultaneous byte acceptance; that byte is dropped.
  - Effective in any state, including DONE and ERR.
  - Next state is LEN, with word_count, checksum and timeout counter cleared.
  - cpu_hold=1, load_done=0 and load_err=0 from the next cycle.
  - Any im_we already registered for that cycle still completes.
- Timeout (TIMEOUT>0):
  - Counter runs in HI, LO and CHK and clears on every accepted byte.
  - Going TIMEOUT consecutive cycles in these states without an accepted byte forces ERR (load_err=1).
- cpu_hold is 0 only in DONE.
- Widths:
  - XOR checksum is 8 bits.
  - word_count is ADDR_W+1 bits so it can hold 2**ADDR_W.
  - im_addr of the last word of a full-size image is 2**ADDR_W-1.

Test Plan:
- Good load. Stream 02,12,34,56,78,0A (checksum 02^12^34^56^78=0A) with in_valid held 1.
  - Required: two writes, addr0=0x1234 then addr1=0x5678, each im_we exactly one cycle.
  - Required: word_count=2, load_done=1, cpu_hold=0, in_ready=0.
- Bad checksum. Same stream with final byte 0B.
  - Required: load_err=1, cpu_hold=1, load_done=0, in_ready=0.
  - Then pulse load_req: state returns to LEN, load_err=0, in_ready=1.
- Gapped input. Same good stream with in_valid low 3 of every 4 cycles, plus in_valid pulses while in DONE.
  - Required: identical writes and completion; bytes offered in DONE are not accepted.
- Timeout. Build with TIMEOUT=16; send 01,AA, then stay idle.
  - Required: load_err rises exactly 16 cycles after AA is accepted; no im_we occurs.
- Full image. Send length byte 00 followed by 256 words with word k=(k,~k).
  - Required: last write has im_addr=0xFF, word_count=256, correct checksum gives load_done.
- Abort paths. Drive rst low after 3 bytes, then do a fresh load.
  - Required: the fresh load succeeds and writes start again at addr 0.
  - Repeat with load_req asserted in the same cycle as an accepted byte: that byte is ignored and the state is LEN.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time byte-stream loader that fills instruction memory and releases the CPU once the XOR checksum matches
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-low
//   in_data    incoming byte, accepted when in_valid && in_ready
//   in_valid   in_data is valid
//   in_ready   loader can accept a byte (combinational, high in LEN/HI/LO/CHK)
//   load_req   one-cycle pulse aborting/restarting a load, wins over a same-cycle byte
//   im_we      instruction memory write strobe, one cycle per word
//   im_addr    instruction memory write address
//   im_wdata   16-bit instruction word {hi, lo}
//   cpu_hold   CPU held in reset, low only once the image is loaded and verified
//   load_done  image loaded and checksum correct
//   load_err   checksum mismatch or inter-byte timeout
//   word_count words written in the current load
module prog_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [15:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [2:0] {S_LEN, S_HI, S_LO, S_CHK, S_DONE, S_ERR} state_t;
  state_t          r_state;
  logic [7:0]      r_hi;
  logic [7:0]      r_sum;
  logic [ADDR_W:0] r_n;
  logic [TW-1:0]   r_tmo;
  logic            w_acc;
  logic            w_run;
  logic            w_tmo;
  logic [ADDR_W:0] w_wc_next;
  assign in_ready  = (r_state == S_LEN) || w_run;
  assign w_run     = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CHK);
  assign w_acc     = in_valid && in_ready;
  assign w_wc_next = word_count + {{ADDR_W{1'b0}}, 1'b1};
  // r_tmo holds idle cycles already spent; the edge completing the TIMEOUT-th idle cycle forces ERR
  assign w_tmo     = (TIMEOUT != 0) && w_run && !w_acc && (r_tmo == TW'(TIMEOUT - 1));
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_LEN;
      r_hi       <= '0;
      r_sum      <= '0;
      r_n        <= '0;
      r_tmo      <= '0;
      im_we      <= 1'b0;
      im_addr    <= '0;
      im_wdata   <= '0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      word_count <= '0;
    end else begin
      im_we <= 1'b0;
      if (load_req) begin
        r_state    <= S_LEN;
        r_sum      <= '0;
        r_tmo      <= '0;
        word_count <= '0;
        cpu_hold   <= 1'b1;
        load_done  <= 1'b0;
        load_err   <= 1'b0;
      end else begin
        if (w_run)
          r_tmo <= w_acc ? '0 : r_tmo + TW'(1);
        if (w_tmo) begin
          r_state  <= S_ERR;
          load_err <= 1'b1;
        end else if (w_acc) begin
          case (r_state)
            S_LEN: begin
              // a zero length byte means a full 2**ADDR_W word image
              r_n     <= (in_data == 8'd0) ? ((ADDR_W+1)'(1) << ADDR_W) : (ADDR_W+1)'(in_data);
              r_sum   <= in_data;
              r_tmo   <= '0;
              r_state <= S_HI;
            end
            S_HI: begin
              r_hi    <= in_data;
              r_sum   <= r_sum ^ in_data;
              r_state <= S_LO;
            end
            S_LO: begin
              r_sum      <= r_sum ^ in_data;
              im_we      <= 1'b1;
              im_wdata   <= {r_hi, in_data};
              im_addr    <= word_count[ADDR_W-1:0];
              word_count <= w_wc_next;
              r_state    <= (w_wc_next == r_n) ? S_CHK : S_HI;
            end
            S_CHK: begin
              r_state   <= (in_data == r_sum) ? S_DONE : S_ERR;
              load_done <= (in_data == r_sum);
              cpu_hold  <= (in_data != r_sum);
              load_err  <= (in_data != r_sum);
            end
            default: r_state <= r_state;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader
module tb_prog_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        load_req = 1'b0;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [8:0]  word_count;
  int          n_chk = 0;
  int          n_err = 0;
  int          nw = 0;
  int          dbl = 0;
  int          nw0;
  logic        prev_we = 1'b0;
  logic [7:0]  wa [0:511];
  logic [15:0] wd [0:511];
  logic [7:0]  sum;
  logic [7:0]  k8;
  prog_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .load_req(load_req), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (im_we) begin
      wa[nw] = im_addr;
      wd[nw] = im_wdata;
      nw = nw + 1;
    end
    if (im_we && prev_we)
      dbl = dbl + 1;
    prev_we = im_we;
  end
  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic put(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic req();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask
  task automatic stream(input logic [7:0] last, input int gap);
    logic [7:0] s [0:5];
    s = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, last};
    for (int i = 0; i < 6; i++) begin
      put(s[i]);
      if (gap > 0) idle(gap);
    end
    idle(2);
  endtask
  task automatic chk_two(input string tag);
    chk({tag, "_nw"}, 32'(nw - nw0), 32'd2);
    chk({tag, "_a0"}, 32'(wa[nw0]), 32'h00);
    chk({tag, "_d0"}, 32'(wd[nw0]), 32'h1234);
    chk({tag, "_a1"}, 32'(wa[nw0+1]), 32'h01);
    chk({tag, "_d1"}, 32'(wd[nw0+1]), 32'h5678);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_we", 32'(im_we), 32'd0);
    chk("rst_addr", 32'(im_addr), 32'd0);
    chk("rst_wdata", 32'(im_wdata), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(in_ready), 32'd1);
    // good load
    nw0 = nw;
    stream(8'h0A, 0);
    chk_two("good");
    chk("good_wc", 32'(word_count), 32'd2);
    chk("good_done", 32'(load_done), 32'd1);
    chk("good_hold", 32'(cpu_hold), 32'd0);
    chk("good_ready", 32'(in_ready), 32'd0);
    chk("good_err", 32'(load_err), 32'd0);
    req();
    chk("req_hold", 32'(cpu_hold), 32'd1);
    chk("req_done", 32'(load_done), 32'd0);
    chk("req_ready", 32'(in_ready), 32'd1);
    chk("req_wc", 32'(word_count), 32'd0);
    // bad checksum
    nw0 = nw;
    stream(8'h0B, 0);
    chk_two("bad");
    chk("bad_err", 32'(load_err), 32'd1);
    chk("bad_hold", 32'(cpu_hold), 32'd1);
    chk("bad_done", 32'(load_done), 32'd0);
    chk("bad_ready", 32'(in_ready), 32'd0);
    req();
    chk("bad_req_err", 32'(load_err), 32'd0);
    chk("bad_req_ready", 32'(in_ready), 32'd1);
    // gapped input, then offers in DONE
    nw0 = nw;
    stream(8'h0A, 3);
    chk_two("gap");
    chk("gap_done", 32'(load_done), 32'd1);
    for (int i = 0; i < 3; i++) begin
      put(8'hFF);
      idle(1);
    end
    idle(2);
    chk("done_nw", 32'(nw - nw0), 32'd2);
    chk("done_wc", 32'(word_count), 32'd2);
    chk("done_stay", 32'(load_done), 32'd1);
    chk("done_err", 32'(load_err), 32'd0);
    req();
    // timeout: error exactly 16 cycles after the AA byte is accepted
    nw0 = nw;
    put(8'h01);
    put(8'hAA);
    idle(15);
    chk("tmo_early", 32'(load_err), 32'd0);
    idle(1);
    chk("tmo_err", 32'(load_err), 32'd1);
    chk("tmo_hold", 32'(cpu_hold), 32'd1);
    chk("tmo_nw", 32'(nw - nw0), 32'd0);
    req();
    // full 256-word image
    nw0 = nw;
    sum = 8'h00;
    put(8'h00);
    for (int k = 0; k < 256; k++) begin
      k8 = 8'(k);
      put(k8);
      put(~k8);
      sum = sum ^ k8 ^ ~k8;
    end
    put(sum);
    idle(2);
    chk("full_nw", 32'(nw - nw0), 32'd256);
    chk("full_a1", 32'(wa[nw0+1]), 32'h01);
    chk("full_d1", 32'(wd[nw0+1]), 32'h01FE);
    chk("full_alast", 32'(wa[nw0+255]), 32'hFF);
    chk("full_dlast", 32'(wd[nw0+255]), 32'hFF00);
    chk("full_wc", 32'(word_count), 32'd256);
    chk("full_done", 32'(load_done), 32'd1);
    req();
    // reset mid-load, then fresh load
    put(8'h02);
    put(8'h12);
    put(8'h34);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_wc", 32'(word_count), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    nw0 = nw;
    stream(8'h0A, 0);
    chk_two("after_rst");
    chk("after_rst_done", 32'(load_done), 32'd1);
    req();
    // load_req wins over a same-cycle byte
    put(8'h02);
    put(8'h12);
    in_data  = 8'h34;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    in_valid = 1'b0;
    nw0 = nw;
    idle(2);
    chk("req_drop_nw", 32'(nw - nw0), 32'd0);
    chk("req_drop_wc", 32'(word_count), 32'd0);
    chk("req_drop_ready", 32'(in_ready), 32'd1);
    stream(8'h0A, 0);
    chk_two("after_req");
    chk("after_req_done", 32'(load_done), 32'd1);
    chk("single_cycle_we", 32'(dbl), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
